// File: rtl/mc_control.sv
// Multicycle MIPS sequencing controller: Moore FSM with memory-ready stalls and retired-instruction counter.
// Optional feature: define MC_ILLEGAL_TRAP_EN to make unknown opcodes trap in a sink state instead of acting as a NOP.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 (waits on mem_ready)
// DECODE   | register read, branch target precompute
// MEMADR   | lw/sw effective address
// MEMRD    | data read (waits on mem_ready)
// MEMWR    | data write (waits on mem_ready)
// MEMWB    | lw register writeback
// EXECUTE  | R-type ALU operation
// ALUWB    | R-type register writeback
// BRANCH   | beq compare and conditional PC load
// ADDIEX   | addi ALU operation
// ADDIWB   | addi register writeback
// JUMP     | PC load from jump target
// ILLEGAL  | unknown opcode (NOP or trap)
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcen,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic [CNT_W-1:0] instret,
    output logic             halted
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB, S_EXECUTE,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_ILLEGAL
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             pcwrite, branch, retire;
    logic             irwrite_s, memwrite_s, regwrite_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_s = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite_s = mem_ready;
                pcwrite   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                // strobe stays up through the stall; memory commits on the ready cycle
                iord       = 1'b1;
                memwrite_s = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg   = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                branch     = 1'b1;
                pcsrc      = 2'b01;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
                state_d = S_ILLEGAL;
`else
                retire  = 1'b1;
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    // write enables are masked combinationally so nothing commits while reset is held
    assign irwrite  = irwrite_s & reset;
    assign memwrite = memwrite_s & reset;
    assign regwrite = regwrite_s & reset;
    assign pcen     = (pcwrite | (branch & zero)) & reset;
    assign instret  = instret_q;

`ifdef MC_ILLEGAL_TRAP_EN
    assign halted = (state_q == S_ILLEGAL);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle expected outputs built from instruction-level rules.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [31:0] instret;
    logic        halted;

    always #5 clk = ~clk;

    mc_control dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .instret(instret), .halted(halted)
    );

    localparam logic [7:0] F_IORD = 8'h80, F_MW = 8'h40, F_IRW = 8'h20, F_PCEN = 8'h10;
    localparam logic [7:0] F_RD = 8'h08, F_M2R = 8'h04, F_RW = 8'h02, F_ASA = 8'h01;
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

    typedef struct {
        logic        mr;
        logic        zero;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [15:0] exp;
        logic        retire;
    } step_t;

    step_t       q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = 0;
    logic [5:0]  cur_op, cur_funct;

    wire [15:0] obs_vec = {iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca,
                           alusrcb, pcsrc, alucontrol, halted};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [5:0] op_of(input int kind, input logic [5:0] ill_op);
        case (kind)
            K_LW:    return 6'b100011;
            K_SW:    return 6'b101011;
            K_R:     return 6'b000000;
            K_BEQ:   return 6'b000100;
            K_ADDI:  return 6'b001000;
            K_J:     return 6'b000010;
            default: return ill_op;
        endcase
    endfunction

    task automatic push(input logic mr, input logic z, input logic [7:0] f, input logic [1:0] asb,
                        input logic [1:0] pcs, input logic [2:0] alu, input logic h, input logic ret);
        step_t e;
        e.mr = mr; e.zero = z; e.op = cur_op; e.funct = cur_funct;
        e.exp = {f, asb, pcs, alu, h};
        e.retire = ret;
        q.push_back(e);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction; fs/ms = stall cycles on fetch / data access.
    task automatic push_instr(input int kind, input logic [5:0] fn, input logic z,
                              input int fs, input int ms, input logic [5:0] ill_op);
        cur_op = op_of(kind, ill_op);
        cur_funct = fn;
        repeat (fs) push(1'b0, rb(), 8'h00, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
        push(1'b1, rb(), F_IRW | F_PCEN, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
        push(rb(), rb(), 8'h00, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0);
        case (kind)
            K_LW: begin
                push(rb(), rb(), F_ASA, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0);
                repeat (ms) push(1'b0, rb(), F_IORD, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
                push(1'b1, rb(), F_IORD, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
                push(rb(), rb(), F_RW | F_M2R, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1);
            end
            K_SW: begin
                push(rb(), rb(), F_ASA, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0);
                repeat (ms) push(1'b0, rb(), F_IORD | F_MW, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
                push(1'b1, rb(), F_IORD | F_MW, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1);
            end
            K_R: begin
                push(rb(), rb(), F_ASA, 2'b00, 2'b00, alu_of(fn), 1'b0, 1'b0);
                push(rb(), rb(), F_RD | F_RW, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1);
            end
            K_BEQ: push(rb(), z, F_ASA | (z ? F_PCEN : 8'h00), 2'b00, 2'b01, 3'b110, 1'b0, 1'b1);
            K_ADDI: begin
                push(rb(), rb(), F_ASA, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0);
                push(rb(), rb(), F_RW, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1);
            end
            K_J: push(rb(), rb(), F_PCEN, 2'b00, 2'b10, 3'b010, 1'b0, 1'b1);
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                repeat (ms + 3) push(rb(), rb(), 8'h00, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0);
`else
                push(rb(), rb(), 8'h00, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1);
`endif
            end
        endcase
    endtask

    // Called at a falling edge; plays up to n queued cycles and returns at a falling edge.
    task automatic run_queue(input int n);
        step_t e;
        int done = 0;
        while (q.size() > 0 && done < n) begin
            e = q.pop_front();
            chk("instret", instret, model_cnt);
            mem_ready = e.mr; zero = e.zero; op = e.op; funct = e.funct;
            #1;
            chk("outputs", {16'h0, obs_vec}, {16'h0, e.exp});
            if (e.retire) model_cnt = model_cnt + 1;
            done++;
            @(negedge clk);
        end
        chk("instret_end", instret, model_cnt);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_instret", instret, 32'd0);
        chk("rst_wen_mr1", {28'h0, irwrite, pcen, memwrite, regwrite}, 32'h0);
        chk("rst_fetch_view", {16'h0, obs_vec}, {16'h0, 8'h00, 2'b01, 2'b00, 3'b010, 1'b0});
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_hold", {16'h0, obs_vec}, {16'h0, 8'h00, 2'b01, 2'b00, 3'b010, 1'b0});
        chk("rst_hold_instret", instret, 32'd0);
        reset = 1'b1;
        model_cnt = 0;
        q.delete();
    endtask

    initial begin
        logic [5:0] fns [6];
        logic [5:0] ills [4];
        int kind;
        reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'h0; funct = 6'h0;
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        ills = '{6'b111111, 6'b000001, 6'b001101, 6'b100000};
        @(negedge clk);
        do_reset();

        push_instr(K_LW, 6'h00, 1'b0, 0, 0, 6'h3f);
        push_instr(K_R, 6'b101010, 1'b0, 0, 0, 6'h3f);
        push_instr(K_BEQ, 6'h00, 1'b1, 0, 0, 6'h3f);
        push_instr(K_BEQ, 6'h00, 1'b0, 0, 0, 6'h3f);
        push_instr(K_SW, 6'h00, 1'b0, 0, 3, 6'h3f);
        push_instr(K_ADDI, 6'h00, 1'b0, 2, 0, 6'h3f);
        push_instr(K_J, 6'h00, 1'b0, 1, 0, 6'h3f);
        push_instr(K_LW, 6'h00, 1'b0, 1, 2, 6'h3f);
        run_queue(1000);
        chk("directed_count", instret, 32'd8);

        push_instr(K_ILL, 6'h00, 1'b0, 0, 2, 6'b111111);
        run_queue(1000);
`ifdef MC_ILLEGAL_TRAP_EN
        chk("trap_halted", {31'h0, halted}, 32'd1);
        do_reset();
`else
        chk("ill_nop_count", instret, 32'd9);
`endif

        // reset in the middle of a stalled load: no writeback, restart at fetch
        push_instr(K_LW, 6'h00, 1'b0, 0, 5, 6'h3f);
        run_queue(5);
        do_reset();
        push_instr(K_R, 6'b100010, 1'b0, 0, 0, 6'h3f);
        run_queue(1000);
        chk("post_reset_count", instret, 32'd1);

        for (int i = 0; i < 250; i++) begin
            kind = int'($urandom_range(0, 6));
            push_instr(kind, (($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 4)]),
                       rb(), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                       ills[$urandom_range(0, 3)]);
            run_queue(1000);
`ifdef MC_ILLEGAL_TRAP_EN
            if (kind == K_ILL) do_reset();
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
